// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter for one router output port
// with downstream credit tracking and a registered flit output.
module output_port_arbiter #(
  parameter int N_INPUTS = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS = 4,
  localparam int CW = $clog2(CREDITS) + 1,
  localparam int OW = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_INPUTS-1:0]            req,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] flit_in,
  input  logic [N_INPUTS-1:0]            tail_in,
  output logic [N_INPUTS-1:0]            pop,
  output logic [DATA_WIDTH-1:0]          flit_out,
  output logic                           valid_out,
  input  logic                           credit_in,
  output logic [CW-1:0]                  credits,
  output logic                           locked,
  output logic [OW-1:0]                  owner
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state;
  logic [OW-1:0] rr_ptr, grant_idx, sel, nxt_ptr, c;
  logic found, send;
  int j;
  always_comb begin
    grant_idx = '0;
    found = 1'b0;
    j = 0;
    c = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      j = int'(rr_ptr) + k;
      j = j >= N_INPUTS ? j - N_INPUTS : j;
      c = OW'(j);
      if (!found && req[c]) begin
        found = 1'b1;
        grant_idx = c;
      end
    end
  end
  assign locked = state == LOCKED;
  assign sel = locked ? owner : grant_idx;
  // sends are gated by the registered count, so a credit arriving at zero helps only next cycle
  assign send = !reset && credits != '0 && (locked ? req[owner] : found);
  assign pop = send ? {{(N_INPUTS-1){1'b0}}, 1'b1} << sel : '0;
  assign nxt_ptr = sel == OW'(N_INPUTS - 1) ? '0 : sel + OW'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      credits <= CW'(CREDITS);
      flit_out <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= send;
      if (send && !credit_in) credits <= credits - CW'(1);
      else if (credit_in && !send && credits != CW'(CREDITS)) credits <= credits + CW'(1);
      if (send) begin
        flit_out <= flit_in[sel*DATA_WIDTH +: DATA_WIDTH];
        owner <= sel;
        state <= tail_in[sel] ? IDLE : LOCKED;
        if (tail_in[sel]) rr_ptr <= nxt_ptr;
      end
    end
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed vectors with a flit scoreboard drained by a valid_out monitor.
module tb_output_port_arbiter;
  localparam int N = 5;
  localparam int DW = 32;
  localparam int CR = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] tail_in = '0;
  logic [N-1:0] pop;
  logic [N*DW-1:0] flit_in;
  logic [DW-1:0] flit_out;
  logic valid_out;
  logic credit_in = 1'b0;
  logic locked;
  logic [2:0] credits;
  logic [2:0] owner;
  int tests = 0;
  int fails = 0;
  int ovf = 0;
  int cnt [N];
  logic [DW-1:0] sb [$];
  logic [N-1:0] g2 [6] = '{5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100, 5'b10000};

  always #5 clk = ~clk;

  output_port_arbiter #(.N_INPUTS(N), .DATA_WIDTH(DW), .CREDITS(CR)) dut (
    .clk(clk), .reset(reset), .req(req), .flit_in(flit_in), .tail_in(tail_in),
    .pop(pop), .flit_out(flit_out), .valid_out(valid_out), .credit_in(credit_in),
    .credits(credits), .locked(locked), .owner(owner)
  );

  function automatic logic [DW-1:0] mk(int i, int n);
    return DW'((i << 16) | n);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) flit_in[i*DW +: DW] = mk(i, cnt[i]);
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // credit_in at full count with no send is a protocol violation; the directed run makes exactly one
  always @(negedge clk) begin
    if (!reset && credit_in && credits == 3'(CR) && pop == '0) ovf++;
    if (valid_out) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious valid_out: got flit %0h expected none", flit_out);
      end else chk("flit_out", flit_out, sb.pop_front());
    end
  end

  task automatic cyc(input logic [N-1:0] ep);
    @(negedge clk);
    chk("pop", 32'(pop), 32'(ep));
    for (int i = 0; i < N; i++) if (ep[i]) sb.push_back(mk(i, cnt[i]));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (ep[i]) cnt[i]++;
    drive();
  endtask

  initial begin
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst pop", 32'(pop), 0);
    chk("rst credits", 32'(credits), CR);
    chk("rst locked", 32'(locked), 0);
    chk("rst valid", 32'(valid_out), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) begin
      cyc('0);
      chk("idle credits", 32'(credits), CR);
      chk("idle locked", 32'(locked), 0);
      chk("idle valid", 32'(valid_out), 0);
    end
    req = 5'b10110;
    tail_in = '1;
    credit_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(g2[k]);
      chk("rr credits", 32'(credits), CR);
    end
    req = '0;
    credit_in = 1'b0;
    cyc('0);
    tail_in = 5'b00001;
    credit_in = 1'b1;
    req = 5'b01000;
    cyc(5'b01000);
    chk("wh locked", 32'(locked), 1);
    chk("wh owner", 32'(owner), 3);
    req = 5'b01001;
    cyc(5'b01000);
    chk("wh locked", 32'(locked), 1);
    cyc(5'b01000);
    chk("wh locked", 32'(locked), 1);
    tail_in = 5'b01001;
    cyc(5'b01000);
    chk("wh unlock", 32'(locked), 0);
    req = 5'b00001;
    cyc(5'b00001);
    chk("wh owner0", 32'(owner), 0);
    credit_in = 1'b0;
    req = '0;
    cyc('0);
    tail_in = '0;
    req = 5'b00100;
    repeat (4) cyc(5'b00100);
    chk("cr empty", 32'(credits), 0);
    repeat (2) begin
      cyc('0);
      chk("cr stall locked", 32'(locked), 1);
    end
    credit_in = 1'b1;
    cyc('0);
    chk("cr one", 32'(credits), 1);
    credit_in = 1'b0;
    cyc(5'b00100);
    chk("cr used", 32'(credits), 0);
    cyc('0);
    req = '0;
    credit_in = 1'b1;
    cyc('0);
    cyc('0);
    chk("cr two", 32'(credits), 2);
    chk("bubble locked", 32'(locked), 1);
    req = 5'b00100;
    tail_in = 5'b00100;
    cyc(5'b00100);
    chk("cr send+credit", 32'(credits), 2);
    chk("tail unlock", 32'(locked), 0);
    req = '0;
    cyc('0);
    cyc('0);
    chk("cr full", 32'(credits), CR);
    cyc('0);
    chk("cr saturate", 32'(credits), CR);
    credit_in = 1'b0;
    tail_in = '0;
    req = 5'b00010;
    cyc(5'b00010);
    cyc(5'b00010);
    chk("mid credits", 32'(credits), 2);
    chk("mid locked", 32'(locked), 1);
    reset = 1'b1;
    #1;
    chk("ar locked", 32'(locked), 0);
    chk("ar credits", 32'(credits), CR);
    chk("ar valid", 32'(valid_out), 0);
    chk("ar pop", 32'(pop), 0);
    chk("ar owner", 32'(owner), 0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    req = 5'b00011;
    tail_in = '1;
    cyc(5'b00001);
    cyc(5'b00010);
    req = '0;
    cyc('0);
    cyc('0);
    chk("sb drained", 32'(sb.size()), 0);
    chk("overflow events", 32'(ovf), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
